// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM state type, default LFSR configuration and period helper.
package lfsr_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, ERROR} state_e;

    localparam int         DEF_LENGTH = 4;
    localparam logic [3:0] DEF_TAPS   = 4'b1001;
    localparam logic [3:0] DEF_SEED   = 4'd1;

    function automatic int max_period(input int len);
        return (1 << len) - 1;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: Fibonacci-style shift register with parallel load and step enable.
import lfsr_pkg::*;

module lfsr_core #(
    parameter int               LENGTH = DEF_LENGTH,
    parameter logic [LENGTH-1:0] TAPS  = DEF_TAPS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [LENGTH-1:0] seed_i,
    input  logic              step_i,
    output logic [LENGTH-1:0] q_o,
    output logic [LENGTH-1:0] nxt_o
);

    logic [LENGTH-1:0] q_q, q_d;

    assign nxt_o = {q_q[LENGTH-2:0], ^(q_q & TAPS)};
    assign q_d   = load_i ? seed_i : step_i ? nxt_o : q_q;
    assign q_o   = q_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_q <= '0;
        else      q_q <= q_d;
    end

endmodule

// File: rtl/lfsr_ctrl.sv
// lfsr_ctrl: seeded LFSR word source with valid/ready output and lock-up detection.
// Define PERIOD_CHECK_EN to build the period counter behind period_vld/len/ok.
import lfsr_pkg::*;

module lfsr_ctrl #(
    parameter int                LENGTH  = DEF_LENGTH,
    parameter logic [LENGTH-1:0] TAPS    = DEF_TAPS,
    parameter logic [LENGTH-1:0] DEFAULT = DEF_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [LENGTH-1:0] seed_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LENGTH-1:0] out_data,
    output logic              busy,
    output logic              seed_fix,
    output logic              err,
    output logic              period_vld,
    output logic [LENGTH:0]   period_len,
    output logic              period_ok
);

    state_e            state_q;
    logic [LENGTH-1:0] seed_q, q, nxt;
    logic              valid_q, busy_q, fix_q, err_q;
    logic              xfer, lock;

    assign xfer = valid_q & out_ready;
    assign lock = (q == '0) | (nxt == q);

    lfsr_core #(.LENGTH(LENGTH), .TAPS(TAPS)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == LOAD),
        .seed_i (seed_q),
        .step_i (xfer),
        .q_o    (q),
        .nxt_o  (nxt)
    );

    // ERROR shares IDLE's start handling so a reseed clears the fault
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            seed_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            fix_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ERROR: if (start) begin
                    state_q <= LOAD;
                    seed_q  <= (seed_in == '0) ? DEFAULT : seed_in;
                    fix_q   <= seed_in == '0;
                    busy_q  <= 1'b1;
                    err_q   <= 1'b0;
                end
                LOAD: begin
                    state_q <= RUN;
                    valid_q <= 1'b1;
                end
                RUN: if (stop) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end else if (lock) begin
                    state_q <= ERROR;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_data  = q;
    assign busy      = busy_q;
    assign seed_fix  = fix_q;
    assign err       = err_q;

`ifdef PERIOD_CHECK_EN
    localparam logic [LENGTH:0] MAXP = (LENGTH+1)'(max_period(LENGTH));

    logic [LENGTH:0] cnt_q, cnt_inc, plen_q;
    logic            pvld_q, pok_q;

    assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            plen_q <= '0;
            pvld_q <= 1'b0;
            pok_q  <= 1'b0;
        end else begin
            pvld_q <= 1'b0;
            if (state_q == LOAD) cnt_q <= '0;
            else if (xfer && nxt == seed_q) begin
                plen_q <= cnt_inc;
                pok_q  <= cnt_inc == MAXP;
                pvld_q <= 1'b1;
                cnt_q  <= '0;
            end else if (xfer) cnt_q <= cnt_inc;
        end
    end

    assign period_vld = pvld_q;
    assign period_len = plen_q;
    assign period_ok  = pok_q;
`else
    assign period_vld = 1'b0;
    assign period_len = '0;
    assign period_ok  = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_ctrl.sv
// tb_lfsr_ctrl: vector table for the default LFSR plus hand sequences for lock-up and reset.
module tb_lfsr_ctrl;

`ifdef PERIOD_CHECK_EN
    localparam bit PC = 1'b1;
`else
    localparam bit PC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, ready;
    logic [3:0] seed;
    logic       valid, busy, fix, err, pvld, pok;
    logic [3:0] data;
    logic [4:0] plen;
    logic       start_b, stop_b, ready_b;
    logic [3:0] seed_b;
    logic       valid_b, busy_b, fix_b, err_b, pvld_b, pok_b;
    logic [3:0] data_b;
    logic [4:0] plen_b;

    always #5 clk = ~clk;

    lfsr_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .seed_in(seed),
        .out_valid(valid), .out_ready(ready), .out_data(data), .busy(busy),
        .seed_fix(fix), .err(err), .period_vld(pvld), .period_len(plen), .period_ok(pok)
    );

    lfsr_ctrl #(.TAPS(4'b0000)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .seed_in(seed_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b), .busy(busy_b),
        .seed_fix(fix_b), .err(err_b), .period_vld(pvld_b), .period_len(plen_b), .period_ok(pok_b)
    );

    typedef struct {
        logic       st, sp;
        logic [3:0] sd;
        logic       rdy, v;
        logic [3:0] d;
        logic       b, f, e, pv;
        logic [4:0] pl;
        logic       pk;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0, n_bad = 0;
    bit   done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic sp, input logic [3:0] sd, input logic rdy,
                       input logic v, input logic [3:0] d, input logic b, input logic f,
                       input logic e, input logic pv);
        if (pv) done = 1'b1;
        vq.push_back('{st, sp, sd, rdy, v, d, b, f, e, pv & PC,
                       (done && PC) ? 5'd15 : 5'd0, done && PC});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"}, valid, 0);
        chk({tag, ".data"},  data,  0);
        chk({tag, ".busy"},  busy,  0);
        chk({tag, ".fix"},   fix,   0);
        chk({tag, ".err"},   err,   0);
        chk({tag, ".pvld"},  pvld,  0);
        chk({tag, ".plen"},  plen,  0);
        chk({tag, ".pok"},   pok,   0);
    endtask

    initial begin
        logic [3:0] words [15];
        logic [3:0] wb [4];
        words = '{4'd3, 4'd7, 4'd15, 4'd14, 4'd13, 4'd10, 4'd5, 4'd11,
                  4'd6, 4'd12, 4'd9, 4'd2, 4'd4, 4'd8, 4'd1};
        wb    = '{4'd2, 4'd4, 4'd8, 4'd0};

        // seed 1, full period
        add(1, 0, 4'd1, 0,  0, 4'd0, 1, 0, 0, 0);
        add(0, 0, 4'd0, 0,  1, 4'd1, 1, 0, 0, 0);
        for (int k = 0; k < 15; k++) add(0, 0, 4'd0, 1, 1, words[k], 1, 0, 0, k == 14);
        add(0, 1, 4'd0, 0,  0, 4'd1, 0, 0, 0, 0);
        // zero seed substitutes DEFAULT; transfer completes in the stop cycle
        add(1, 0, 4'd0, 0,  0, 4'd1, 1, 1, 0, 0);
        add(0, 0, 4'd0, 0,  1, 4'd1, 1, 1, 0, 0);
        add(0, 0, 4'd0, 1,  1, 4'd3, 1, 1, 0, 0);
        add(0, 1, 4'd0, 1,  0, 4'd7, 0, 1, 0, 0);
        // seed 6 with backpressure
        add(1, 0, 4'd6, 0,  0, 4'd7, 1, 0, 0, 0);
        add(0, 0, 4'd0, 0,  1, 4'd6, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) add(0, 0, 4'd0, 0, 1, 4'd6, 1, 0, 0, 0);
        add(0, 0, 4'd0, 1,  1, 4'd12, 1, 0, 0, 0);
        add(0, 0, 4'd0, 1,  1, 4'd9, 1, 0, 0, 0);
        // start ignored in RUN, stop wins over start, stop ignored in LOAD
        add(1, 0, 4'd5, 1,  1, 4'd2, 1, 0, 0, 0);
        add(1, 1, 4'd4, 0,  0, 4'd2, 0, 0, 0, 0);
        add(1, 0, 4'd9, 0,  0, 4'd2, 1, 0, 0, 0);
        add(0, 1, 4'd0, 0,  1, 4'd9, 1, 0, 0, 0);
        add(0, 0, 4'd0, 1,  1, 4'd2, 1, 0, 0, 0);

        rst = 1'b0; start = 0; stop = 0; ready = 0; seed = 0;
        start_b = 0; stop_b = 0; ready_b = 0; seed_b = 0;
        repeat (2) @(posedge clk);
        #1 chk_reset("reset");
        chk("reset.valid_b", valid_b, 0);
        chk("reset.err_b",   err_b,   0);
        @(negedge clk) rst = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            start = vq[i].st; stop = vq[i].sp; seed = vq[i].sd; ready = vq[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.valid", i), valid, vq[i].v);
            chk($sformatf("v%0d.data", i),  data,  vq[i].d);
            chk($sformatf("v%0d.busy", i),  busy,  vq[i].b);
            chk($sformatf("v%0d.fix", i),   fix,   vq[i].f);
            chk($sformatf("v%0d.err", i),   err,   vq[i].e);
            chk($sformatf("v%0d.pvld", i),  pvld,  vq[i].pv);
            chk($sformatf("v%0d.plen", i),  plen,  vq[i].pl);
            chk($sformatf("v%0d.pok", i),   pok,   vq[i].pk);
        end

        // reset asserted mid-RUN, away from the edge
        @(negedge clk);
        start = 0; stop = 0; ready = 1;
        #2 rst = 1'b0;
        #1 chk_reset("midrst");
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("idle_after_rst.valid", valid, 0);
        chk("idle_after_rst.data", data, 0);
        @(negedge clk) begin start = 1; seed = 4'd5; end
        @(negedge clk) start = 0;
        @(posedge clk) #1;
        chk("restart.valid", valid, 1);
        chk("restart.data", data, 5);

        // TAPS=0 shifts to zero and locks up
        @(negedge clk) begin start_b = 1; seed_b = 4'd1; end
        @(negedge clk) start_b = 0;
        @(posedge clk) #1;
        chk("lock.first", data_b, 1);
        chk("lock.valid", valid_b, 1);
        @(negedge clk) ready_b = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk) #1;
            chk($sformatf("lock.w%0d", k), data_b, wb[k]);
        end
        @(posedge clk) #1;
        chk("lock.err", err_b, 1);
        chk("lock.valid_lo", valid_b, 0);
        chk("lock.busy", busy_b, 0);
        @(negedge clk) begin start_b = 1; seed_b = 4'd3; end
        @(posedge clk) #1;
        chk("reseed.err", err_b, 0);
        chk("reseed.busy", busy_b, 1);
        @(negedge clk) start_b = 0;
        @(posedge clk) #1;
        chk("reseed.data", data_b, 3);
        chk("reseed.valid", valid_b, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
